// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU operand/opcode pins: buffers packed commands in a FIFO, holds the ALU
// pins for a fixed number of cycles per command and returns the captured result as a response.
module alu_cmd_driver #(
  parameter int unsigned DATA_WIDTH  = 5,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [2:0]            cmd_op1_op,
  input  logic [1:0]            cmd_op2_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  alu_en,
  output logic                  alu_op1_en,
  output logic                  alu_op2_en,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [2:0]            alu_op1_op,
  output logic [1:0]            alu_op2_op,
  input  logic [DATA_WIDTH:0]   alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH:0]   rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned EntryW = 7 + 2 * DATA_WIDTH;
  localparam int unsigned PtrW   = $clog2(CMD_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES);
  localparam logic [CntW-1:0]  Full     = CntW'(CMD_DEPTH);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StResp} state_e;

  state_e                  state_q;
  logic [EntryW-1:0]       mem_q [CMD_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q, count_d;
  logic [HoldW-1:0]        hold_q;
  logic                    push, pop;
  logic [EntryW-1:0]       head;
  logic [1:0]              head_mode;
  logic [2:0]              head_op1;
  logic [1:0]              head_op2;
  logic [DATA_WIDTH-1:0]   head_a, head_b;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state_q == StIdle) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];
  assign {head_mode, head_op1, head_op2, head_a, head_b} = head;
  assign busy = (state_q != StIdle) || (count_q != '0);

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_mode, cmd_op1_op, cmd_op2_op, cmd_a, cmd_b};
    end
  end

  // Ready follows the registered fill level, so a pop never frees a slot in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q   <= count_d;
      cmd_ready <= (count_d != Full);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      alu_en       <= 1'b0;
      alu_op1_en   <= 1'b0;
      alu_op2_en   <= 1'b0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_op1_op   <= '0;
      alu_op2_op   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            if (head_mode == 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state_q   <= StResp;
            end else begin
              alu_en       <= 1'b1;
              alu_op1_en   <= head_mode[1];
              alu_op2_en   <= head_mode[0];
              alu_operand1 <= head_a;
              alu_operand2 <= head_b;
              alu_op1_op   <= head_op1;
              alu_op2_op   <= head_op2;
              hold_q       <= '0;
              state_q      <= StDrive;
            end
          end
        end
        StDrive: begin
          if (hold_q == HoldLast) begin
            alu_en     <= 1'b0;
            alu_op1_en <= 1'b0;
            alu_op2_en <= 1'b0;
            state_q    <= StCapture;
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        // The ALU holds its output while disabled, so the result is sampled one cycle late.
        StCapture: begin
          rsp_data  <= alu_result;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU on the pins, scoreboard of expected responses
// filled at command acceptance and drained by an independent response monitor.
module tb_alu_cmd_driver;

  localparam int unsigned DW   = 5;
  localparam int unsigned HOLD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_mode;
  logic [2:0]    cmd_op1_op;
  logic [1:0]    cmd_op2_op;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          alu_en, alu_op1_en, alu_op2_en;
  logic [DW-1:0] alu_operand1, alu_operand2;
  logic [2:0]    alu_op1_op;
  logic [1:0]    alu_op2_op;
  logic [DW:0]   alu_result;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW:0]   rsp_data;

  alu_cmd_driver #(.DATA_WIDTH(DW), .CMD_DEPTH(4), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_op1_op(cmd_op1_op), .cmd_op2_op(cmd_op2_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_en(alu_en), .alu_op1_en(alu_op1_en),
    .alu_op2_en(alu_op2_en), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_op1_op(alu_op1_op), .alu_op2_op(alu_op2_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW+1:0] exp_q [$];   // {err, data}
  logic [DW:0]   ref_held = '0;
  int            exp_pulses = 0;
  int            pulses = 0;
  int            rsp_cnt = 0;
  logic [DW:0]   last_data = '0;
  logic          last_err = 1'b0;
  int            bp_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ALU function: op2 set takes precedence when Operand2 is enabled; op1 111 keeps the output.
  function automatic logic [DW:0] alu_f(input logic [1:0] mode, input logic [2:0] op1,
                                        input logic [1:0] op2, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [DW:0] prev);
    logic signed [DW:0] sa, sb;
    sa = {a[DW-1], a};
    sb = {b[DW-1], b};
    if (mode[0]) begin
      case (op2)
        2'b00:   return sb - sa;
        2'b01:   return sa + sb + 1;
        2'b10:   return -sb;
        default: return sb + 2;
      endcase
    end else if (mode[1]) begin
      case (op1)
        3'b000:  return sa + sb;
        3'b001:  return sa - sb;
        3'b010:  return sa & sb;
        3'b011:  return sa | sb;
        3'b100:  return sa ^ sb;
        3'b101:  return -sa;
        3'b110:  return sa <<< 1;
        default: return prev;
      endcase
    end
    return prev;
  endfunction

  // ALU pin model: first enabled cycle settles, later enabled cycles compute.
  logic [DW:0] alu_q = '0;
  logic        settled = 1'b0;
  assign alu_result = alu_q;
  always @(posedge clk) begin
    if (!alu_en) settled <= 1'b0;
    else if (!settled) settled <= 1'b1;
    else alu_q <= alu_f({alu_op1_en, alu_op2_en}, alu_op1_op, alu_op2_op,
                        alu_operand1, alu_operand2, alu_q);
  end

  task automatic model_push(input logic [1:0] m, input logic [2:0] o1, input logic [1:0] o2,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (m == 2'b00) begin
      exp_q.push_back({1'b1, {(DW+1){1'b0}}});
    end else begin
      ref_held = alu_f(m, o1, o2, a, b, ref_held);
      exp_q.push_back({1'b0, ref_held});
      exp_pulses++;
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic push(input logic [1:0] m, input logic [2:0] o1, input logic [1:0] o2,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    int t = 0;
    cmd_mode = m; cmd_op1_op = o1; cmd_op2_op = o2; cmd_a = a; cmd_b = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'(t), 32'd0);
    end else begin
      @(posedge clk);
      model_push(m, o1, o2, a, b);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Response monitor: scoreboard pops, stability under backpressure, alu_en pulse width.
  initial begin
    int          run_len = 0;
    logic        held_v = 1'b0;
    logic [DW+1:0] held = '0;
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
        held_v = 1'b0;
      end else begin
        if (alu_en) begin
          if (run_len == 0) pulses++;
          run_len++;
        end else if (run_len != 0) begin
          chk("alu_en_width", 32'(run_len), 32'(HOLD));
          run_len = 0;
        end
        if (rsp_valid) begin
          if (held_v) chk("rsp_stable", 32'({rsp_err, rsp_data}), 32'(held));
          held_v = 1'b1;
          held = {rsp_err, rsp_data};
          if (rsp_ready) begin
            held_v = 1'b0;
            rsp_cnt++;
            last_data = rsp_data;
            last_err = rsp_err;
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 32'({rsp_err, rsp_data}), 32'hffff_ffff);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_data", 32'(rsp_data), 32'(e[DW:0]));
              chk("rsp_err", 32'(rsp_err), 32'(e[DW+1]));
            end
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] all_outs();
    return 32'({cmd_ready, alu_en, alu_op1_en, alu_op2_en, alu_operand1, alu_operand2,
                alu_op1_op, alu_op2_op, rsp_valid, rsp_data, rsp_err, busy});
  endfunction

  initial begin
    int lat;
    int base;
    int t;
    logic [DW:0] saved;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_mode = '0; cmd_op1_op = '0; cmd_op2_op = '0; cmd_a = '0; cmd_b = '0;
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 + 3, with latency from acceptance to response
    push(2'b10, 3'b000, 2'b00, 5'd5, 5'd3);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(HOLD + 3));
    drain();
    chk("add_5_3", 32'({last_err, last_data}), 32'({1'b0, 6'd8}));

    push(2'b10, 3'b001, 2'b00, 5'd3, 5'd5);
    drain();
    chk("sub_3_5", 32'({last_err, last_data}), 32'({1'b0, 6'b111110}));

    push(2'b11, 3'b000, 2'b11, 5'd0, 5'd4);
    drain();
    chk("op2_11_b4", 32'(last_data), 32'(6'd6));
    push(2'b01, 3'b000, 2'b00, 5'b10101, 5'b01111);
    drain();
    chk("op2_00", 32'(last_data), 32'(6'b011010));

    base = pulses;
    push(2'b00, 3'b000, 2'b00, 5'd9, 5'd9);
    drain();
    chk("mode00_rsp", 32'({last_err, last_data}), 32'({1'b1, 6'd0}));
    chk("mode00_no_alu_en", 32'(pulses), 32'(base));

    push(2'b10, 3'b111, 2'b00, 5'd1, 5'd1);
    drain();
    chk("null_holds", 32'({last_err, last_data}), 32'({1'b0, 6'b011010}));

    // Backpressure: one in flight plus four buffered
    bp_mode = 1;
    repeat (2) @(negedge clk);
    base = rsp_cnt;
    push(2'b10, 3'b000, 2'b00, 5'd1, 5'd2);
    push(2'b10, 3'b011, 2'b00, 5'd4, 5'd3);
    push(2'b01, 3'b000, 2'b10, 5'd0, 5'd7);
    push(2'b10, 3'b101, 2'b00, 5'd6, 5'd0);
    push(2'b11, 3'b000, 2'b01, 5'd2, 5'd2);
    cmd_valid = 1'b1;
    repeat (3) begin
      chk("full_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("busy_backpressure", 32'(busy), 32'd1);
    chk("no_rsp_while_stalled", 32'(rsp_cnt), 32'(base));
    bp_mode = 0;
    drain();
    chk("bp_rsp_count", 32'(rsp_cnt - base), 32'd5);
    chk("busy_after_drain", 32'(busy), 32'd0);

    // Randomized traffic with random response backpressure
    bp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           5'($urandom), 5'($urandom));
    end
    bp_mode = 0;
    drain();
    chk("busy_after_random", 32'(busy), 32'd0);

    // Reset during DRIVE drops the command
    saved = ref_held;
    push(2'b10, 3'b000, 2'b00, 5'd1, 5'd2);
    push(2'b10, 3'b000, 2'b00, 5'd3, 5'd3);
    t = 0;
    while (!alu_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_drive", 32'(alu_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_drive", all_outs(), 32'd0);
    exp_q.delete();
    ref_held = saved;
    exp_pulses = exp_pulses - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = rsp_cnt;
    repeat (10) @(negedge clk);
    chk("no_rsp_after_reset", 32'(rsp_cnt), 32'(base));
    chk("busy_after_reset", 32'(busy), 32'd0);
    push(2'b10, 3'b001, 2'b00, 5'd7, 5'd1);
    drain();
    chk("post_reset_cmd", 32'({last_err, last_data}), 32'({1'b0, 6'd6}));
    chk("alu_en_pulses", 32'(pulses), 32'(exp_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
